// File: rtl/sfifo_pkg.sv
// Shared widths, header field layout and FSM encoding for the packet unpacker.
package sfifo_pkg;
   localparam int WORD_W     = 64;
   localparam int BEAT_WORDS = 8;
   localparam int TID_W      = 22;
   localparam int PKTL_W     = 16;

   localparam int HDR_PKTL_LSB = 48;
   localparam int HDR_PKTL_MSB = 63;
   localparam int HDR_TID_LSB  = 0;
   localparam int HDR_TID_MSB  = 21;

   typedef enum logic {HDR, PAY} state_e;

   function automatic logic [PKTL_W-1:0] hdr_pktl(input logic [WORD_W-1:0] w);
      return w[HDR_PKTL_MSB:HDR_PKTL_LSB];
   endfunction

   function automatic logic [TID_W-1:0] hdr_tid(input logic [WORD_W-1:0] w);
      return w[HDR_TID_MSB:HDR_TID_LSB];
   endfunction
endpackage

// File: rtl/sfifo_word_ring.sv
// Circular 64-bit word store: up to 8 words written per cycle, one word read per cycle.
module sfifo_word_ring
   import sfifo_pkg::*;
#(
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en_i,
   input  logic [3:0]                   wr_len_i,
   input  logic [BEAT_WORDS*WORD_W-1:0] wr_data_i,
   input  logic                         rd_en_i,
   output logic [WORD_W-1:0]            head_o,
   output logic [AW:0]                  count_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wptr_q;
   logic [AW:0]       rptr_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (wr_en_i) wptr_q <= wptr_q + (AW+1)'(wr_len_i);
         if (rd_en_i) rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

   // NOTE: the word store carries no reset; pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         for (int k = 0; k < BEAT_WORDS; k++) begin
            if (k < int'(wr_len_i)) mem_q[wptr_q[AW-1:0] + AW'(k)] <= wr_data_i[k*WORD_W +: WORD_W];
         end
      end
   end

   assign count_o = wptr_q - rptr_q;
   assign head_o  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/sfifo_pkt_unpack.sv
// Buffers 0..8 words per beat, parses packet headers and streams payload words with SOP/EOP/tId.
module sfifo_pkt_unpack
   import sfifo_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNTW  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         inValid,
   input  logic [3:0]                   inLen,
   input  logic [BEAT_WORDS*WORD_W-1:0] inData,
   output logic                         inReady,
   output logic                         outValid,
   input  logic                         outReady,
   output logic [WORD_W-1:0]            outData,
   output logic                         outSop,
   output logic                         outEop,
   output logic [TID_W-1:0]             outTid,
   output logic [CNTW-1:0]              pktCnt,
   output logic [CNTW-1:0]              dropCnt,
   output logic                         errSticky
);

   localparam int AW = $clog2(DEPTH);

   logic [WORD_W-1:0] head;
   logic [AW:0]       count;
   logic [AW:0]       free;
   logic              accept;
   logic              wr_en;
   logic              rd_en;

   state_e            state_q, state_d;
   logic [PKTL_W-1:0] remaining_q, remaining_d;
   logic              sop_q, sop_d;
   logic [TID_W-1:0]  tid_q, tid_d;
   logic [CNTW-1:0]   pkt_cnt_q, pkt_cnt_d;
   logic [CNTW-1:0]   drop_cnt_q, drop_cnt_d;
   logic              err_q, err_d;

   sfifo_word_ring #(.DEPTH(DEPTH)) u_ring (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (wr_en),
      .wr_len_i (inLen),
      .wr_data_i(inData),
      .rd_en_i  (rd_en),
      .head_o   (head),
      .count_o  (count)
   );

   assign free    = (AW+1)'(DEPTH) - count;
   assign inReady = !rst && (free >= (AW+1)'(BEAT_WORDS));
   assign accept  = inValid && inReady;
   assign wr_en   = accept && (inLen <= 4'd8);
   assign err_d   = err_q | (accept && (inLen > 4'd8));

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      sop_d       = sop_q;
      tid_d       = tid_q;
      pkt_cnt_d   = pkt_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      rd_en       = 1'b0;
      outValid    = 1'b0;
      outData     = '0;
      outSop      = 1'b0;
      outEop      = 1'b0;

      unique case (state_q)
         HDR: begin
            if (count != '0) begin
               rd_en       = 1'b1;
               remaining_d = hdr_pktl(head);
               tid_d       = hdr_tid(head);
               if (hdr_pktl(head) == '0) begin
                  drop_cnt_d = drop_cnt_q + CNTW'(1);
               end else begin
                  state_d = PAY;
                  sop_d   = 1'b1;
               end
            end
         end
         PAY: begin
            outValid = !rst && (count != '0);
            outData  = head;
            outSop   = sop_q;
            outEop   = (remaining_q == PKTL_W'(1));
            if (outValid && outReady) begin
               rd_en       = 1'b1;
               remaining_d = remaining_q - PKTL_W'(1);
               sop_d       = 1'b0;
               if (remaining_q == PKTL_W'(1)) begin
                  pkt_cnt_d = pkt_cnt_q + CNTW'(1);
                  state_d   = HDR;
               end
            end
         end
         default: state_d = HDR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HDR;
         remaining_q <= '0;
         sop_q       <= 1'b0;
         tid_q       <= '0;
         pkt_cnt_q   <= '0;
         drop_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         sop_q       <= sop_d;
         tid_q       <= tid_d;
         pkt_cnt_q   <= pkt_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         err_q       <= err_d;
      end
   end

   assign outTid    = tid_q;
   assign pktCnt    = pkt_cnt_q;
   assign dropCnt   = drop_cnt_q;
   assign errSticky = err_q;

endmodule

// File: tb/tb_sfifo_pkt_unpack.sv
// Scoreboard bench for sfifo_pkt_unpack: a word-stream packet model predicts the payload sequence.
module tb_sfifo_pkt_unpack;

   localparam int DEPTH = 16;
   localparam int CNTW  = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         inValid;
   logic [3:0]   inLen;
   logic [511:0] inData;
   logic         inReady;
   logic         outValid;
   logic         outReady;
   logic [63:0]  outData;
   logic         outSop;
   logic         outEop;
   logic [21:0]  outTid;
   logic [31:0]  pktCnt;
   logic [31:0]  dropCnt;
   logic         errSticky;

   always #5 clk = ~clk;

   sfifo_pkt_unpack #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (inValid),
      .inLen    (inLen),
      .inData   (inData),
      .inReady  (inReady),
      .outValid (outValid),
      .outReady (outReady),
      .outData  (outData),
      .outSop   (outSop),
      .outEop   (outEop),
      .outTid   (outTid),
      .pktCnt   (pktCnt),
      .dropCnt  (dropCnt),
      .errSticky(errSticky)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: walks the accepted word stream as header/payload records.
   typedef struct {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [21:0] tid;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] stream[$];
   int          m_left  = 0;
   logic        m_first = 1'b0;
   logic [21:0] m_tid   = '0;
   int          m_pkts  = 0;
   int          m_drops = 0;

   task automatic model_word(input logic [63:0] w);
      exp_t e;
      if (m_left == 0) begin
         m_left = int'(w[63:48]);
         m_tid  = w[21:0];
         if (m_left == 0) m_drops++;
         else m_first = 1'b1;
      end else begin
         e.data = w;
         e.sop  = m_first;
         e.eop  = (m_left == 1);
         e.tid  = m_tid;
         exp_q.push_back(e);
         m_first = 1'b0;
         if (m_left == 1) m_pkts++;
         m_left--;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      stream.delete();
      m_left  = 0;
      m_first = 1'b0;
      m_pkts  = 0;
      m_drops = 0;
   endtask

   function automatic logic [63:0] hdr(input int pktl, input logic [21:0] tid);
      logic [25:0] rsv;
      rsv = 26'($urandom);
      return {16'(pktl), rsv, tid};
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   logic [63:0] bw [8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send_beat(input int len);
      int cyc;
      cyc     = 0;
      inValid = 1'b1;
      inLen   = 4'(len);
      for (int k = 0; k < 8; k++) inData[k*64 +: 64] = (k < len) ? bw[k] : rnd64();
      @(negedge clk);
      while (!inReady && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("beat_accept", inReady, 1);
      if (inReady && len <= 8) begin
         for (int k = 0; k < len; k++) model_word(bw[k]);
      end
      step();
      inValid = 1'b0;
      inLen   = '0;
   endtask

   task automatic send_chunk(input int len);
      for (int k = 0; k < len; k++) bw[k] = stream.pop_front();
      send_beat(len);
   endtask

   task automatic send_stream();
      int len;
      while (stream.size() > 0) begin
         len = $urandom_range(8, 0);
         if (len > stream.size()) len = stream.size();
         send_chunk(len);
      end
   endtask

   task automatic drain_and_count(input string tag);
      int cyc;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 2000) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      check({tag, "_drain_left"}, exp_q.size(), 0);
      repeat (3) step();
      check({tag, "_pktCnt"}, pktCnt, m_pkts);
      check({tag, "_dropCnt"}, dropCnt, m_drops);
   endtask

   // Sink ready driver: fixed level or 50% random, updated just after each rising edge.
   int   ready_mode  = 0;
   logic ready_level = 1'b1;

   initial begin
      outReady = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         outReady = (ready_mode != 0) ? 1'($urandom_range(1, 0)) : ready_level;
      end
   end

   // Monitor: compares every payload handshake with the scoreboard and enforces the hold rule.
   int n_hs = 0;

   initial begin
      exp_t        e;
      logic        stall_q;
      logic [63:0] p_data;
      logic        p_sop, p_eop;
      logic [21:0] p_tid;
      stall_q = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q) begin
               check("hold_valid", outValid, 1);
               check("hold_data", outData, p_data);
               check("hold_sop", outSop, p_sop);
               check("hold_eop", outEop, p_eop);
               check("hold_tid", outTid, p_tid);
            end
            if (outValid && outReady) begin
               if (exp_q.size() == 0) begin
                  check("spurious_word", outValid, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", outData, e.data);
                  check("out_sop", outSop, e.sop);
                  check("out_eop", outEop, e.eop);
                  check("out_tid", outTid, e.tid);
               end
               n_hs++;
            end
            stall_q = outValid && !outReady;
            p_data  = outData;
            p_sop   = outSop;
            p_eop   = outEop;
            p_tid   = outTid;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
      $fatal(1, "timeout");
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_outValid"}, outValid, 0);
      check({tag, "_outData"}, outData, 0);
      check({tag, "_outSop"}, outSop, 0);
      check({tag, "_outEop"}, outEop, 0);
      check({tag, "_outTid"}, outTid, 0);
      check({tag, "_pktCnt"}, pktCnt, 0);
      check({tag, "_dropCnt"}, dropCnt, 0);
      check({tag, "_errSticky"}, errSticky, 0);
      check({tag, "_inReady"}, inReady, 1);
   endtask

   initial begin
      int base;
      int cyc;
      int pl;
      rst     = 1'b1;
      inValid = 1'b0;
      inLen   = '0;
      inData  = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_inReady", inReady, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("post_rst");
      step();

      // Single packet, header and payload in one beat; first valid two cycles after accept.
      bw[0] = hdr(2, 22'h15A5A);
      bw[1] = 64'hA1;
      bw[2] = 64'hA2;
      send_beat(3);
      @(negedge clk);
      check("lat_cycle1_outValid", outValid, 0);
      @(negedge clk);
      check("lat_cycle2_outValid", outValid, 1);
      drain_and_count("t1");

      // Zero-length header dropped, then a one-word packet.
      bw[0] = hdr(0, 22'h00111);
      bw[1] = hdr(1, 22'h00222);
      bw[2] = 64'hBEEF;
      send_beat(3);
      drain_and_count("t2");

      // Backpressure: fill the store to 16 words while the sink stalls mid-packet.
      ready_level = 1'b0;
      bw[0] = hdr(16, 22'h00033);
      send_beat(1);
      repeat (3) step();
      for (int k = 0; k < 8; k++) bw[k] = 64'h300 + 64'(k);
      send_beat(8);
      for (int k = 0; k < 8; k++) bw[k] = 64'h308 + 64'(k);
      send_beat(8);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("full_inReady", inReady, 0);
      end
      step();
      ready_level = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("refill_inReady", inReady, (i >= 8));
      end
      step();
      drain_and_count("t3");

      // 20-word packet across three beats with a randomly stalling sink.
      ready_mode = 1;
      stream.push_back(hdr(20, 22'h2C0DE));
      for (int k = 0; k < 20; k++) stream.push_back(rnd64());
      send_chunk(8);
      send_chunk(8);
      send_chunk(5);
      drain_and_count("t4");

      // Oversized beat sets the sticky error and writes nothing.
      bw[0] = hdr(1, 22'h0BAD0);
      for (int k = 1; k < 8; k++) bw[k] = rnd64();
      send_beat(9);
      check("errSticky_set", errSticky, 1);
      bw[0] = hdr(2, 22'h01234);
      bw[1] = 64'hC1;
      bw[2] = 64'hC2;
      send_beat(3);
      drain_and_count("t5");
      check("errSticky_held", errSticky, 1);

      // Random packet mix, random beat split (including empty beats).
      for (int p = 0; p < 8; p++) begin
         pl = (p == 7) ? $urandom_range(12, 1) : $urandom_range(12, 0);
         stream.push_back(hdr(pl, 22'($urandom)));
         for (int k = 0; k < pl; k++) stream.push_back(rnd64());
      end
      send_stream();
      drain_and_count("t6");

      // Reset in the middle of a 10-word packet after three payload handshakes.
      ready_mode  = 0;
      ready_level = 1'b1;
      stream.push_back(hdr(10, 22'h3F00F));
      for (int k = 0; k < 10; k++) stream.push_back(rnd64());
      base = n_hs;
      send_chunk(8);
      cyc = 0;
      while (n_hs < base + 3 && cyc < 100) begin
         step();
         cyc++;
      end
      check("mid_pkt_handshakes", n_hs - base, 3);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      check("mid_rst_inReady", inReady, 0);
      check("mid_rst_outValid", outValid, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("mid_rst");
      step();
      bw[0] = hdr(1, 22'h2AAAA);
      bw[1] = 64'h1234_5678_9ABC_DEF0;
      send_beat(2);
      drain_and_count("t7");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sfifo_pkt_unpack.md
Name: sfifo_pkt_unpack

Overview:
Downstream consumer of the VXE streaming FIFO output stage. Accepts 0–8 64-bit words per cycle from the 512-bit output bus and buffers them in a circular word store. Parses 64-bit packet headers and emits payload one word per cycle over a valid/ready interface, tagged with SOP/EOP and the transaction id. Keeps packet and error counters for the emulation readback path.

Parameters:
DEPTH, 16, word-buffer depth in 64-bit words; power of 2, minimum 16
CNTW, 32, width of pktCnt and dropCnt

Ports:
clk  in  1  single clock
rst  in  1  synchronous active-high reset
inValid  in  1  input words present
inLen  in  4  number of valid 64-bit words, 0..8
inData  in  512  word k at bits [64k+63:64k]; word 0 is first in stream order
inReady  out  1  stage can accept a full 8-word beat
outValid  out  1  payload word available
outReady  in  1  sink accepts word
outData  out  64  payload word
outSop  out  1  first payload word of packet
outEop  out  1  last payload word of packet
outTid  out  22  tId of current packet
pktCnt  out  CNTW  packets completed (EOP handshakes)
dropCnt  out  CNTW  zero-length headers dropped
errSticky  out  1  inLen>8 seen; cleared only by rst

Behaviour:
- Header word format: [63:48] pktl (payload word count), [47:22] reserved (ignored), [21:0] tId.
- Buffer: wptr/rptr are log2(DEPTH)+1 bits and wrap naturally. count = wptr-rptr. free = DEPTH-count.
- inReady = !rst && (free >= 8). Accept = inValid && inReady.
- On accept with inLen<=8: write words 0..inLen-1 at wptr..wptr+inLen-1 mod DEPTH, wptr += inLen. inLen=0 is a legal no-op.
- On accept with inLen>8: write nothing, set errSticky.
- Written words are visible at the head the cycle after the write; there is no same-cycle bypass.
- FSM, reset state HDR:
  - HDR: if count!=0, pop the head word (rptr+1) and latch pktl into remaining and tId into outTid.
    - pktl==0: dropCnt+1 and stay in HDR.
    - else: go to PAY with sopPend=1.
  - PAY: outValid = (count!=0). outData = head word. outSop = sopPend. outEop = (remaining==1).
    - On outValid&&outReady: pop, remaining-1, sopPend=0.
    - If remaining==1, pktCnt+1 and go to HDR.
- Pops and pushes occur in the same cycle independently. count uses both deltas, so full-to-not-full and empty-to-not-empty transitions are exact.
- Holding rule: while outValid && !outReady, outData, outSop, outEop and outTid hold stable.
- Header-to-first-payload latency: header accepted at cycle N → popped at N+1 → outValid at N+2 at the earliest.
- Back-to-back packets:
  - After an EOP handshake, the next header is consumed in the following cycle, so there is a one-cycle bubble per packet.
  - A header and payload may arrive in the same input beat, and a packet may span beats.
- Counters wrap modulo 2^CNTW.
- Reset, any cycle including mid-packet: wptr=rptr=0, state=HDR, remaining=0, sopPend=0, outValid=0, outData=0, outSop=0, outEop=0, outTid=0, pktCnt=0, dropCnt=0, errSticky=0, inReady=0 while rst=1. Partial packets are discarded.
- Sink must not depend on outValid being asserted with outReady=1 as a precondition; ready may be held high constantly.

Decomposition:
- Shared package sfifo_pkg:
  - WORD_W=64, BEAT_WORDS=8, TID_W=22, PKTL_W=16
  - header field bit positions
  - FSM state enum {HDR, PAY}
- Sub-module sfifo_word_ring: the DEPTH×64 circular store with multi-word write (0..8 words/cycle), single-word read, pointers and count.
- Top level holds the FSM, counters and handshake logic.

Test Plan:
- After reset, one beat inLen=3: header pktl=2/tId=0x15A5A plus words 0xA1, 0xA2 → outData 0xA1 (outSop=1, outTid=0x15A5A) then 0xA2 (outEop=1); first outValid 2 cycles after accept; pktCnt=1.
- Header pktl=0 followed by header pktl=1 with word 0xBEEF in one 3-word beat → dropCnt=1; single word 0xBEEF with outSop=outEop=1; pktCnt=1.
- outReady=0, two 8-word beats accepted (count reaches 16) → inReady=0 with count=16 and is not reasserted until count<=8. Release outReady → words drain in order with no loss or duplication.
- Packet pktl=20 split across 3 beats (8,8,5 words incl. header), random outReady 50% → 20 words in order, SOP only on first, EOP only on 20th, outputs stable during stalls, pointers wrap correctly.
- inLen=9 beat then a valid packet → errSticky=1, no words written, following packet delivered correctly.
- rst pulsed mid-packet after 3 of 10 payload words → all outputs/counters 0 the next cycle. A new packet pktl=1 after reset delivers with outSop=outEop=1.
